// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt controller feeding CP0 EPC/Cause writes and fetch redirects
// Ports:
//   clk, rst (sync, active-low)
//   irq_i, irq_mask_i, global_ie_i          : external interrupts, per-line and global enables
//   sync_exc_i, sync_code_i                 : synchronous exception and its cause code
//   inst_boundary_i, pc_cur_i               : async-trap acceptance point and PC to save
//   eret_i, epc_i                           : return request and saved EPC from CP0
//   trap_o, redirect_o, redirect_pc_o       : pipeline flush and PC redirect
//   write_epc_o, write_cause_o, cause_o,
//   epc_pc_o                                : CP0 write strobes and data
//   in_handler_o, pending_o                 : exception level and sticky pending lines
module exc_ctrl #(
   parameter int          NUM_IRQ     = 8,
   parameter logic [31:0] HANDLER_VEC = 32'h0000_0008
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_mask_i,
   input  logic               global_ie_i,
   input  logic               sync_exc_i,
   input  logic [4:0]         sync_code_i,
   input  logic               inst_boundary_i,
   input  logic [31:0]        pc_cur_i,
   input  logic               eret_i,
   input  logic [31:0]        epc_i,
   output logic               trap_o,
   output logic               redirect_o,
   output logic [31:0]        redirect_pc_o,
   output logic               write_epc_o,
   output logic               write_cause_o,
   output logic [4:0]         cause_o,
   output logic [31:0]        epc_pc_o,
   output logic               in_handler_o,
   output logic [NUM_IRQ-1:0] pending_o
);
   typedef enum logic [1:0] {IDLE, SAVE, HANDLER, RETURN} state_t;
   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, svc_q, svc_d, elig;
   logic [4:0]         cause_q, cause_d;
   logic [31:0]        pc_q, pc_d, rpc_q, rpc_d;
   logic               nest_q, nest_d;
   logic [3:0]         idx;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         irq_q   <= '0;
         pend_q  <= '0;
         svc_q   <= '0;
         cause_q <= '0;
         pc_q    <= '0;
         rpc_q   <= '0;
         nest_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_i;
         pend_q  <= pend_d;
         svc_q   <= svc_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         nest_q  <= nest_d;
      end
   end
   // lowest-indexed eligible line wins
   always_comb begin
      elig = (global_ie_i && inst_boundary_i) ? (pend_q & irq_mask_i) : '0;
      idx  = '0;
      for (int n = NUM_IRQ - 1; n >= 0; n--)
         if (elig[n]) idx = 4'(n);
   end
   always_comb begin
      state_d = state_q;
      svc_d   = svc_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      nest_d  = 1'b0;
      // a new edge on the line being serviced must survive the clear
      pend_d  = (pend_q & ~((state_q == SAVE) ? svc_q : '0)) | (irq_i & ~irq_q);
      rpc_d   = redirect_pc_o;
      case (state_q)
         IDLE: begin
            if (sync_exc_i) begin
               state_d = SAVE;
               cause_d = sync_code_i;
               pc_d    = pc_cur_i;
               svc_d   = '0;
            end else if (|elig) begin
               state_d = SAVE;
               cause_d = {1'b1, idx};
               pc_d    = pc_cur_i;
               svc_d   = NUM_IRQ'(1) << idx;
            end
         end
         SAVE: state_d = HANDLER;
         HANDLER: begin
            // nested fault re-traps without touching EPC; a coincident eret is dropped
            if (sync_exc_i) begin
               nest_d  = 1'b1;
               cause_d = sync_code_i;
            end else if (eret_i) begin
               state_d = RETURN;
            end
         end
         RETURN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      trap_o        = (state_q == SAVE) || nest_q;
      redirect_o    = trap_o || (state_q == RETURN);
      redirect_pc_o = trap_o ? HANDLER_VEC : (state_q == RETURN) ? epc_i : rpc_q;
      write_epc_o   = state_q == SAVE;
      write_cause_o = trap_o;
      cause_o       = cause_q;
      epc_pc_o      = pc_q;
      in_handler_o  = state_q == HANDLER;
      pending_o     = pend_q;
   end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl with directed vectors
module tb_exc_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_i, irq_mask_i;
   logic        global_ie_i, sync_exc_i, inst_boundary_i, eret_i;
   logic [4:0]  sync_code_i;
   logic [31:0] pc_cur_i, epc_i;
   logic        trap_o, redirect_o, write_epc_o, write_cause_o, in_handler_o;
   logic [31:0] redirect_pc_o, epc_pc_o;
   logic [4:0]  cause_o;
   logic [7:0]  pending_o;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        trap, redir, wepc, wcause, ck_cause, ck_epc;
      logic [4:0]  cause;
      logic [31:0] rpc, epc;
   } ev_t;
   ev_t q[$];
   ev_t mon_e;

   exc_ctrl dut (
      .clk(clk), .rst(rst), .irq_i(irq_i), .irq_mask_i(irq_mask_i),
      .global_ie_i(global_ie_i), .sync_exc_i(sync_exc_i), .sync_code_i(sync_code_i),
      .inst_boundary_i(inst_boundary_i), .pc_cur_i(pc_cur_i), .eret_i(eret_i),
      .epc_i(epc_i), .trap_o(trap_o), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .write_epc_o(write_epc_o),
      .write_cause_o(write_cause_o), .cause_o(cause_o), .epc_pc_o(epc_pc_o),
      .in_handler_o(in_handler_o), .pending_o(pending_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ev_t trap_ev(input logic wepc, input logic [4:0] c, input logic [31:0] e);
      ev_t r;
      r.trap = 1'b1; r.redir = 1'b1; r.wepc = wepc; r.wcause = 1'b1;
      r.ck_cause = 1'b1; r.ck_epc = wepc; r.cause = c; r.rpc = 32'h8; r.epc = e;
      return r;
   endfunction

   function automatic ev_t ret_ev(input logic [31:0] t);
      ev_t r;
      r.trap = 1'b0; r.redir = 1'b1; r.wepc = 1'b0; r.wcause = 1'b0;
      r.ck_cause = 1'b0; r.ck_epc = 1'b0; r.cause = '0; r.rpc = t; r.epc = '0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (trap_o || redirect_o || write_epc_o || write_cause_o) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event trap=%b redir=%b wepc=%b wcause=%b pc=%h",
                     trap_o, redirect_o, write_epc_o, write_cause_o, redirect_pc_o);
         end else begin
            mon_e = q.pop_front();
            chk("ev_trap", 32'(trap_o), 32'(mon_e.trap));
            chk("ev_redirect", 32'(redirect_o), 32'(mon_e.redir));
            chk("ev_write_epc", 32'(write_epc_o), 32'(mon_e.wepc));
            chk("ev_write_cause", 32'(write_cause_o), 32'(mon_e.wcause));
            chk("ev_redirect_pc", redirect_pc_o, mon_e.rpc);
            if (mon_e.ck_cause) chk("ev_cause", 32'(cause_o), 32'(mon_e.cause));
            if (mon_e.ck_epc) chk("ev_epc_pc", epc_pc_o, mon_e.epc);
         end
      end
   end

   initial begin
      rst = 1'b0; irq_i = '0; irq_mask_i = 8'hFF; global_ie_i = 1'b1;
      sync_exc_i = 1'b0; sync_code_i = '0; inst_boundary_i = 1'b1;
      pc_cur_i = 32'h100; eret_i = 1'b0; epc_i = '0;
      tick(); tick();
      chk("rst_trap", 32'(trap_o), 0);
      chk("rst_redirect_pc", redirect_pc_o, 0);
      chk("rst_cause", 32'(cause_o), 0);
      chk("rst_epc_pc", epc_pc_o, 0);
      chk("rst_pending", 32'(pending_o), 0);
      chk("rst_in_handler", 32'(in_handler_o), 0);
      rst = 1'b1;
      tick();
      // single interrupt on line 3
      irq_i = 8'h08;
      q.push_back(trap_ev(1'b1, 5'h13, 32'h100));
      tick();
      chk("irq_pending_set", 32'(pending_o), 32'h08);
      tick();
      tick();
      chk("irq_in_handler", 32'(in_handler_o), 1);
      chk("irq_pending_clr", 32'(pending_o), 0);
      irq_i = '0;
      // eret from handler
      epc_i = 32'h204; eret_i = 1'b1;
      q.push_back(ret_ev(32'h204));
      tick();
      eret_i = 1'b0;
      chk("ret_in_handler", 32'(in_handler_o), 0);
      tick();
      // eret in idle is ignored
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      chk("idle_eret_redirect", 32'(redirect_o), 0);
      tick();
      chk("idle_eret_in_handler", 32'(in_handler_o), 0);
      // sync beats simultaneous interrupts, then lines 2 and 5 in order
      pc_cur_i = 32'h200; sync_exc_i = 1'b1; sync_code_i = 5'h08; irq_i = 8'h24;
      q.push_back(trap_ev(1'b1, 5'h08, 32'h200));
      tick();
      sync_exc_i = 1'b0;
      tick();
      chk("prio_pending", 32'(pending_o), 32'h24);
      epc_i = 32'h300; eret_i = 1'b1;
      q.push_back(ret_ev(32'h300));
      tick();
      eret_i = 1'b0; pc_cur_i = 32'h240;
      q.push_back(trap_ev(1'b1, 5'h12, 32'h240));
      tick(); tick(); tick();
      chk("prio_pending_after2", 32'(pending_o), 32'h20);
      eret_i = 1'b1;
      q.push_back(ret_ev(32'h300));
      tick();
      eret_i = 1'b0;
      q.push_back(trap_ev(1'b1, 5'h15, 32'h240));
      tick(); tick(); tick();
      chk("prio_pending_after5", 32'(pending_o), 0);
      eret_i = 1'b1;
      q.push_back(ret_ev(32'h300));
      tick();
      eret_i = 1'b0; irq_i = '0;
      tick();
      // gating: global enable, mask, instruction boundary
      global_ie_i = 1'b0; irq_i = 8'h02;
      tick(); tick(); tick(); tick();
      chk("gate_ie_pending", 32'(pending_o), 32'h02);
      chk("gate_ie_in_handler", 32'(in_handler_o), 0);
      global_ie_i = 1'b1; irq_mask_i = 8'hFD;
      tick(); tick();
      chk("gate_mask_pending", 32'(pending_o), 32'h02);
      irq_mask_i = 8'hFF; inst_boundary_i = 1'b0;
      tick(); tick();
      chk("gate_ib_pending", 32'(pending_o), 32'h02);
      chk("gate_ib_in_handler", 32'(in_handler_o), 0);
      inst_boundary_i = 1'b1;
      q.push_back(trap_ev(1'b1, 5'h11, 32'h240));
      tick(); tick();
      chk("gate_pending_clr", 32'(pending_o), 0);
      chk("gate_in_handler", 32'(in_handler_o), 1);
      // nested fault with coincident eret
      sync_exc_i = 1'b1; sync_code_i = 5'h0A; eret_i = 1'b1;
      q.push_back(trap_ev(1'b0, 5'h0A, 32'h0));
      tick();
      sync_exc_i = 1'b0; eret_i = 1'b0;
      chk("nest_in_handler", 32'(in_handler_o), 1);
      tick();
      chk("nest_still_handler", 32'(in_handler_o), 1);
      chk("nest_epc_kept", epc_pc_o, 32'h240);
      epc_i = 32'h204; eret_i = 1'b1;
      q.push_back(ret_ev(32'h204));
      tick();
      eret_i = 1'b0;
      tick();
      // reset while in SAVE
      pc_cur_i = 32'h380; sync_exc_i = 1'b1; sync_code_i = 5'h0C; irq_i = 8'h80;
      q.push_back(trap_ev(1'b1, 5'h0C, 32'h380));
      tick();
      sync_exc_i = 1'b0; irq_i = '0; rst = 1'b0;
      tick();
      chk("mid_rst_trap", 32'(trap_o), 0);
      chk("mid_rst_wepc", 32'(write_epc_o), 0);
      chk("mid_rst_wcause", 32'(write_cause_o), 0);
      chk("mid_rst_pending", 32'(pending_o), 0);
      chk("mid_rst_in_handler", 32'(in_handler_o), 0);
      chk("mid_rst_cause", 32'(cause_o), 0);
      rst = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_idle", 32'(in_handler_o), 0);
      chk("queue_empty", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
